// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin, packet-granular sharing of the AVR USB-serial TX channel among NUM_SRC byte sources.
// Latency : request seen in IDLE -> grant next cycle -> first byte the same cycle as the grant; one IDLE bubble between packets.
// Backpr. : tx_busy or a missing byte from the owner holds the channel; src_ready only pulses for the owner on an accepted byte.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   src_valid[i]   source i has a byte; the first valid of a packet is its request
//   src_data       source i byte at [8*i+7:8*i]
//   src_last[i]    source i byte is the final byte of its packet (qualified by src_valid)
//   src_ready[i]   byte from source i accepted this cycle (combinational, one-hot or zero)
//   tx_busy        AVR transmitter cannot take a byte
//   tx_data        byte to the AVR (8'h00 when nothing is sent)
//   new_tx_data    tx_data strobe, one cycle per byte
//   grant          registered one-hot channel owner, zero when idle
//   active         registered packet-in-progress flag
//   timeout_err    one-cycle pulse when a stalled packet is aborted
//
// Optional feature macro: TX_ARB_TIMEOUT_EN. When defined, an owner that withholds
// src_valid for TIMEOUT_CYCLES consecutive cycles mid-packet loses the channel.
// Without it the owner keeps the channel indefinitely and timeout_err is tied low.
module uart_tx_arbiter #(
  parameter int NUM_SRC        = 3,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic [8*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_last,
  output logic [NUM_SRC-1:0]   src_ready,
  input  logic                 tx_busy,
  output logic [7:0]           tx_data,
  output logic                 new_tx_data,
  output logic [NUM_SRC-1:0]   grant,
  output logic                 active,
  output logic                 timeout_err
);

  localparam int                 PTR_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W:0]     NUM_SRC_X = (PTR_W+1)'(NUM_SRC);
  localparam logic [PTR_W-1:0]   LAST_IDX  = PTR_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] ONE_HOT0  = NUM_SRC'(1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;        // highest-priority source for the next arbitration
  logic [PTR_W-1:0] gidx;       // binary index of the current owner

  logic             win_found;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W:0]   cand;
  logic             fire;
  logic             fire_last;
  logic             stall_expire;
  logic [PTR_W-1:0] ptr_after_owner;

  // Rotating priority scan: ptr, ptr+1, ... wrapping. The one-bit-wider sum
  // never exceeds 2*NUM_SRC-2, so a single conditional subtract is a full modulo
  // and the pointer never lands on an index >= NUM_SRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= NUM_SRC_X) cand = cand - NUM_SRC_X;
      if (!win_found && src_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // rst gates the byte path so a reset landing mid-packet issues nothing more,
  // even in the cycle before the synchronous reset takes effect on state.
  assign fire            = (state == SEND) && !rst && src_valid[gidx] && !tx_busy;
  assign fire_last       = fire && src_last[gidx];
  assign ptr_after_owner = (gidx == LAST_IDX) ? '0 : gidx + 1'b1;

  assign new_tx_data = fire;
  assign src_ready   = fire ? grant : '0;
  assign tx_data     = fire ? src_data[8*gidx +: 8] : 8'h00;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int             CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] stall_cnt;

  // Only cycles where the owner has no byte are counted; tx_busy back-pressure
  // with a byte waiting is the AVR's fault, not the source's.
  assign stall_expire = (state == SEND) && !rst && !src_valid[gidx] && (stall_cnt == CNT_LIMIT);
  assign timeout_err  = stall_expire;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || fire) begin
      stall_cnt <= '0;
    end else if (!src_valid[gidx]) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  assign stall_expire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      grant  <= '0;
      active <= 1'b0;
      ptr    <= '0;
      gidx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state  <= SEND;
            grant  <= ONE_HOT0 << win_idx;
            gidx   <= win_idx;
            active <= 1'b1;
          end
        end
        SEND: begin
          // Packet end (or forced abort) hands priority to the next source.
          if (fire_last || stall_expire) begin
            state  <= IDLE;
            grant  <= '0;
            active <= 1'b0;
            ptr    <= ptr_after_owner;
          end
        end
        default: begin
          state  <= IDLE;
          grant  <= '0;
          active <= 1'b0;
        end
      endcase
    end
  end

endmodule
